// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder controller.
// State encoding and legal operand width range.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/half_adder.sv
// One-bit half adder datapath cell.
// Ports: x, y in; s = x^y, c = x&y out.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// One-bit full adder built from two half adders.
// Ports: x, y, ci in; s (sum), co (carry) out.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .x (x),
    .y (y),
    .s (s0),
    .c (c0)
  );

  half_adder u_ha1 (
    .x (s0),
    .y (ci),
    .s (s),
    .c (c1)
  );

  assign co = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder slice, WIDTH cycles per add.
// In: clk, rst, start, a, b, cin. Out: busy, done, sum, cout.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic             s_bit;
  logic             c_bit;
  logic             last;

  full_adder_bit u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (s_bit),
    .co (c_bit)
  );

  // Sum bits enter a_sh at the top as operand bits
  // leave the bottom, so a_sh doubles as the sum shifter.
  if (WIDTH > 1) begin : g_wide
    assign sum_nxt = {s_bit, a_sh[WIDTH-1:1]};
  end else begin : g_one
    assign sum_nxt = s_bit;
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= sum_nxt;
          b_sh  <= b_sh >> 1;
          carry <= c_bit;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            sum   <= sum_nxt;
            cout  <= c_bit;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1).
// Expected results come from plain a+b+cin and a timing model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic rst1;
  logic start1;
  logic a1;
  logic b1;
  logic cin1;
  logic busy1;
  logic done1;
  logic sum1;
  logic cout1;

  serial_adder_ctrl #(.WIDTH(W)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst1),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .cin   (cin1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1)
  );

  typedef struct {
    logic [W:0] res;
    int         done_edge;
  } exp_t;

  exp_t       q[$];
  exp_t       ne;
  exp_t       got_e;
  int         errors  = 0;
  int         checks  = 0;
  int         edge_n  = 0;
  int         next_ok = 0;
  logic [W:0] held    = '0;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (edge %0d)",
               nm, got, want, edge_n);
    end
  endtask

  // Reference model: an add is accepted when start is seen
  // and the previous op (WIDTH+2 cycles) has finished.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      q.delete();
      next_ok = edge_n + 1;
      held    = '0;
    end else if (start && edge_n >= next_ok) begin
      ne.res       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      ne.done_edge = edge_n + W;
      q.push_back(ne);
      next_ok = edge_n + W + 2;
    end
  end

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    check("busy", busy, edge_n <= next_ok - 2);
    if (q.size() > 0 && q[0].done_edge < edge_n) begin
      checks++;
      errors++;
      $display("FAIL done_missing: got none want edge %0d",
               q[0].done_edge);
      void'(q.pop_front());
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_spurious: got done=1 want 0 (edge %0d)",
                 edge_n);
      end else begin
        got_e = q.pop_front();
        check("done_edge", edge_n, got_e.done_edge);
        check("result", {cout, sum}, got_e.res);
        held = got_e.res;
      end
    end else begin
      check("hold", {cout, sum}, held);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [W-1:0] xa,
                    input logic [W-1:0] xb,
                    input logic xc);
    while (edge_n + 1 < next_ok) step(1);
    start = 1'b1;
    a     = xa;
    b     = xb;
    cin   = xc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    while (edge_n + 1 < next_ok) step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int sv;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    rst1   = 1'b1;
    start1 = 1'b0;
    a1     = 1'b0;
    b1     = 1'b0;
    cin1   = 1'b0;
    step(2);
    rst  = 1'b0;
    rst1 = 1'b0;
    step(1);

    op(8'h00, 8'h00, 1'b0);
    wait_idle();
    step(2);
    op(8'hFF, 8'h01, 1'b0);
    wait_idle();
    step(5);
    op(8'hA5, 8'h5A, 1'b1);
    op(8'h3C, 8'h41, 1'b0);
    wait_idle();
    step(1);

    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    cin   = 1'b0;
    step(3);
    a = 8'h10;
    step(27);
    start = 1'b0;
    wait_idle();
    step(1);

    start = 1'b1;
    a     = 8'hF0;
    b     = 8'h0F;
    cin   = 1'b0;
    step(1);
    start = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    op(8'hF0, 8'h0F, 1'b1);
    wait_idle();
    step(2);

    for (int i = 0; i < 300; i++) begin
      start = ($urandom_range(2) == 0);
      a     = W'($urandom);
      b     = W'($urandom);
      cin   = 1'($urandom);
      rst   = ($urandom_range(99) == 0);
      step(1);
    end
    start = 1'b0;
    rst   = 1'b0;
    step(W + 4);

    for (int i = 0; i < 8; i++) begin
      a1     = i[0];
      b1     = i[1];
      cin1   = i[2];
      sv     = i[0] + i[1] + i[2];
      start1 = 1'b1;
      step(1);
      start1 = 1'b0;
      @(negedge clk);
      check("w1_run_done", done1, 1'b0);
      check("w1_run_busy", busy1, 1'b1);
      @(negedge clk);
      check("w1_done", done1, 1'b1);
      check("w1_sum", {cout1, sum1}, sv[1:0]);
      @(negedge clk);
      check("w1_idle_done", done1, 1'b0);
      check("w1_idle_busy", busy1, 1'b0);
      step(1);
    end

    step(W + 4);
    check("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
